// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR tap sequencer.
package fir_pkg;

  localparam int unsigned NTAPS_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Ceiling log2, clamped to at least 1 so a 2-tap filter still gets an address bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mod_addr.sv
// Combinational (base - off) mod NTAPS for operands already in 0..NTAPS-1.
module fir_mod_addr #(
  parameter int unsigned NTAPS = 8,
  parameter int unsigned AW    = 3
) (
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] off,
  output logic [AW-1:0] res
);

  localparam int unsigned W1 = AW + 1;

  // Wrap by adding NTAPS back rather than truncating, so non-power-of-2 depths work.
  always_comb begin
    res = '0;
    if (base >= off) begin
      res = base - off;
    end else begin
      res = AW'(({1'b0, base} + W1'(NTAPS)) - {1'b0, off});
    end
  end

endmodule

// File: rtl/fir_tap_sched.sv
// Sequencer that writes each sample into a circular delay line and walks all taps
// through one shared multicycle multiplier.
module fir_tap_sched
  import fir_pkg::*;
#(
  parameter int unsigned NTAPS = NTAPS_DEF,
  parameter int unsigned AW    = clog2(NTAPS)
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic          isample_vld,
  output logic          osample_rdy,
  output logic          owr_en,
  output logic [AW-1:0] owr_addr,
  output logic [AW-1:0] ord_addr,
  output logic [AW-1:0] ocoef_addr,
  output logic          omul_start,
  input  logic          imul_done,
  output logic          oacc_clr,
  output logic          oacc_en,
  output logic          oout_vld,
  input  logic          iout_rdy
);

  localparam logic [AW-1:0] K_LAST = AW'(NTAPS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rd_addr_c;
  logic [AW-1:0] wptr_inc_c;

  fir_mod_addr #(.NTAPS(NTAPS), .AW(AW)) u_rd_addr (
    .base (wptr_q),
    .off  (k_q),
    .res  (rd_addr_c)
  );

  // Subtracting NTAPS-1 modulo NTAPS is the same as a wrapping increment.
  fir_mod_addr #(.NTAPS(NTAPS), .AW(AW)) u_wptr_inc (
    .base (wptr_q),
    .off  (K_LAST),
    .res  (wptr_inc_c)
  );

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      wptr_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wptr_q  <= wptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wptr_d  = wptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (isample_vld) state_d = S_WRITE;
      end
      S_WRITE: begin
        k_d     = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imul_done) begin
          if (k_q == K_LAST) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + AW'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        if (iout_rdy) begin
          wptr_d  = wptr_inc_c;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decode the registered state; only oacc_en also qualifies on imul_done.
  always_comb begin
    osample_rdy = (state_q == S_IDLE);
    owr_en      = (state_q == S_WRITE);
    oacc_clr    = (state_q == S_WRITE);
    omul_start  = (state_q == S_ISSUE);
    oacc_en     = (state_q == S_WAIT) && imul_done;
    oout_vld    = (state_q == S_DONE);
    owr_addr    = wptr_q;
    ocoef_addr  = k_q;
    ord_addr    = rd_addr_c;
  end

endmodule

// File: tb/tb_fir_tap_sched.sv
// Randomized bench for fir_tap_sched: an 8-tap and a 5-tap instance checked against
// a per-sample transaction model (tap order, addresses, strobes, latency).
module tb_fir_tap_sched;

  localparam logic [31:0] E_IDLE = 32'h20;
  localparam logic [31:0] E_WR   = 32'h18;
  localparam logic [31:0] E_ISS  = 32'h04;
  localparam logic [31:0] E_ACC  = 32'h02;
  localparam logic [31:0] E_OUT  = 32'h01;
  localparam logic [31:0] E_NONE = 32'h00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, vld, done, ordy;

  logic       srdy0, wen0, clr0, mst0, acc0, ov0;
  logic [2:0] wa0, ra0, ca0;
  logic       srdy1, wen1, clr1, mst1, acc1, ov1;
  logic [2:0] wa1, ra1, ca1;

  logic [14:0] obs [2];
  assign obs[0] = {srdy0, wen0, clr0, mst0, acc0, ov0, wa0, ra0, ca0};
  assign obs[1] = {srdy1, wen1, clr1, mst1, acc1, ov1, wa1, ra1, ca1};

  fir_tap_sched #(.NTAPS(8), .AW(3)) u_dut8 (
    .iclk(clk), .irst(rst[0]), .isample_vld(vld[0]), .osample_rdy(srdy0),
    .owr_en(wen0), .owr_addr(wa0), .ord_addr(ra0), .ocoef_addr(ca0),
    .omul_start(mst0), .imul_done(done[0]), .oacc_clr(clr0), .oacc_en(acc0),
    .oout_vld(ov0), .iout_rdy(ordy[0])
  );

  fir_tap_sched #(.NTAPS(5), .AW(3)) u_dut5 (
    .iclk(clk), .irst(rst[1]), .isample_vld(vld[1]), .osample_rdy(srdy1),
    .owr_en(wen1), .owr_addr(wa1), .ord_addr(ra1), .ocoef_addr(ca1),
    .omul_start(mst1), .imul_done(done[1]), .oacc_clr(clr1), .oacc_en(acc1),
    .oout_vld(ov1), .iout_rdy(ordy[1])
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int wptr_m [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] strb(input int d); return 32'(obs[d][14:9]); endfunction
  function automatic logic [31:0] wra(input int d);  return 32'(obs[d][8:6]);  endfunction
  function automatic logic [31:0] rda(input int d);  return 32'(obs[d][5:3]);  endfunction
  function automatic logic [31:0] cfa(input int d);  return 32'(obs[d][2:0]);  endfunction
  function automatic logic rbit(); return 1'($urandom_range(0, 1)); endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_cycles(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      vld[d] = 1'b0; done[d] = rbit(); ordy[d] = rbit();
      settle();
      check("idle_strb", strb(d), E_IDLE);
      tick();
    end
  endtask

  // One full sample transaction; fixed_lat=0 picks a random 1..4 cycle multiplier latency.
  task automatic run_sample(input int d, input int n, input int fixed_lat,
                            input int rdy_delay, input int abort_k, input bit spur);
    int t0, exp_lat, lat;
    logic [31:0] exp_rd;
    vld[d] = 1'b1; done[d] = spur ? rbit() : 1'b0; ordy[d] = rbit();
    settle();
    check("accept_strb", strb(d), E_IDLE);
    t0 = cyc;
    tick();
    vld[d] = rbit(); done[d] = spur ? rbit() : 1'b0;
    settle();
    check("write_strb", strb(d), E_WR);
    check("wr_addr", wra(d), 32'(wptr_m[d]));
    tick();
    exp_lat = 2;
    for (int k = 0; k < n; k++) begin
      vld[d] = rbit(); done[d] = spur ? rbit() : 1'b0;
      settle();
      exp_rd = 32'((wptr_m[d] - k + n) % n);
      check("issue_strb", strb(d), E_ISS);
      check("issue_coef", cfa(d), 32'(k));
      check("issue_rd", rda(d), exp_rd);
      tick();
      lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
      exp_lat += 1 + lat;
      for (int j = 1; j <= lat; j++) begin
        vld[d] = rbit(); ordy[d] = rbit();
        if (k == abort_k && j == 1) begin
          rst[d] = 1'b1; done[d] = 1'b0;
          tick();
          rst[d] = 1'b0; vld[d] = 1'b0;
          wptr_m[d] = 0;
          settle();
          check("abort_strb", strb(d), E_IDLE);
          check("abort_wptr", wra(d), 32'd0);
          return;
        end
        done[d] = (j == lat);
        settle();
        check("wait_strb", strb(d), (j == lat) ? E_ACC : E_NONE);
        check("wait_coef", cfa(d), 32'(k));
        check("wait_rd", rda(d), exp_rd);
        tick();
      end
    end
    check("out_latency", 32'(cyc - t0), 32'(exp_lat));
    for (int i = 0; i <= rdy_delay; i++) begin
      ordy[d] = (i == rdy_delay); vld[d] = rbit(); done[d] = spur ? rbit() : 1'b0;
      settle();
      check("done_strb", strb(d), E_OUT);
      tick();
    end
    wptr_m[d] = (wptr_m[d] + 1) % n;
    vld[d] = 1'b0; ordy[d] = 1'b0; done[d] = 1'b0;
    settle();
    check("back_idle", strb(d), E_IDLE);
  endtask

  initial begin
    rst = 2'b11; vld = '0; done = '0; ordy = '0;
    wptr_m[0] = 0; wptr_m[1] = 0;
    tick(); tick();
    rst = 2'b00;
    settle();
    for (int d = 0; d < 2; d++) begin
      check("rst_strb", strb(d), E_IDLE);
      check("rst_wptr", wra(d), 32'd0);
      check("rst_k", cfa(d), 32'd0);
    end
    tick();

    run_sample(0, 8, 1, 0, -1, 1'b0);
    run_sample(0, 8, 3, 2, -1, 1'b0);
    for (int s = 0; s < 10; s++) run_sample(0, 8, 1, 0, -1, 1'b0);
    run_sample(0, 8, 1, 5, -1, 1'b1);

    idle_cycles(0, 3);
    run_sample(0, 8, 1, 0, 4, 1'b1);
    run_sample(0, 8, 0, 1, -1, 1'b1);

    for (int s = 0; s < 20; s++) begin
      idle_cycles(0, int'($urandom_range(0, 2)));
      run_sample(0, 8, 0, int'($urandom_range(0, 5)), -1, 1'b1);
    end

    for (int s = 0; s < 8; s++) begin
      run_sample(1, 5, (s < 2) ? 1 : 0, int'($urandom_range(0, 3)), -1, 1'b1);
    end
    run_sample(1, 5, 2, 0, 3, 1'b1);
    run_sample(1, 5, 1, 0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
